uart_rx_fifo: RTL and testbench

//   Byte buffer between uart_rx and its consumer (ASCII/digit decoder, display loader).

---
 rtl/uart_rx_fifo.sv | 94 +++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind uart_rx, with a sticky overflow flag.
// Define RXFIFO_OVF_COUNT_EN to add the saturating dropped-byte counter ovf_count.
module uart_rx_fifo #(
   parameter int DW        = 8,
   parameter int DEPTH     = 16,
   parameter int OVF_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            wr_data,
   input  logic                     wr_tick,
   output logic [DW-1:0]            rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   input  logic                     ovf_clr
`ifdef RXFIFO_OVF_COUNT_EN
   ,
   output logic [OVF_CNT_W-1:0]     ovf_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          r_ovf;

   logic          w_full;
   logic          w_rd_fire;
   logic          w_wr_en;
   logic          w_drop;

   assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign rd_valid  = (r_wr_ptr != r_rd_ptr);
   assign w_rd_fire = rd_valid & rd_ready;
   // A read in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign w_wr_en   = wr_tick & (~w_full | w_rd_fire);
   assign w_drop    = wr_tick & w_full & ~w_rd_fire;

   assign level     = r_wr_ptr - r_rd_ptr;
   assign full      = w_full;
   assign overflow  = r_ovf;
   assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: storage has no reset; pointers alone define which entries are live,
   // which keeps the array mappable to plain RAM/LUT storage.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_en)   r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd_fire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

`ifdef RXFIFO_OVF_COUNT_EN
   logic [OVF_CNT_W-1:0] r_ovf_count;

   // Clear and drop together leave exactly one counted drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_count <= '0;
      end else if (ovf_clr) begin
         r_ovf_count <= w_drop ? OVF_CNT_W'(1) : '0;
      end else if (w_drop && (r_ovf_count != '1)) begin
         r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
      end
   end

   assign ovf_count = r_ovf_count;
`else
   if (OVF_CNT_W < 1) begin : g_ovf_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus literal expectations for each scenario.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 8;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] wr_data;
   logic          wr_tick;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [4:0]    level;
   logic          full;
   logic          overflow;
   logic          ovf_clr;
`ifdef RXFIFO_OVF_COUNT_EN
   logic [CW-1:0] ovf_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   uart_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .OVF_CNT_W(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_data  (wr_data),
      .wr_tick  (wr_tick),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .level    (level),
      .full     (full),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
`ifdef RXFIFO_OVF_COUNT_EN
      ,
      .ovf_count(ovf_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: ordered byte queue plus flag/counter.
   logic [DW-1:0] m_q [$];
   logic          m_ovf = 1'b0;
   int            m_cnt = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
         end else begin
            automatic bit fire = (m_q.size() != 0) && rd_ready;
            automatic bit drop = wr_tick && (m_q.size() == DEPTH) && !fire;
            if (fire) void'(m_q.pop_front());
            if (wr_tick && !drop) m_q.push_back(wr_data);
            if (drop)         m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (ovf_clr)                       m_cnt = drop ? 1 : 0;
            else if (drop && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, after the edge has settled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         check("cmp_valid",    32'(rd_valid), 32'(m_q.size() != 0));
         check("cmp_level",    32'(level),    32'(m_q.size()));
         check("cmp_full",     32'(full),     32'(m_q.size() == DEPTH));
         check("cmp_overflow", 32'(overflow), 32'(m_ovf));
         if (m_q.size() != 0) check("cmp_data", 32'(rd_data), 32'(m_q[0]));
`ifdef RXFIFO_OVF_COUNT_EN
         check("cmp_ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
      end
   end

   // Drive one cycle's inputs at a falling edge, return at the next falling edge.
   task automatic cyc(input logic tick, input logic [DW-1:0] d, input logic rdy, input logic clr);
      wr_tick  = tick;
      wr_data  = d;
      rd_ready = rdy;
      ovf_clr  = clr;
      @(negedge clk);
      wr_tick  = 1'b0;
      rd_ready = 1'b0;
      ovf_clr  = 1'b0;
   endtask

   task automatic fill(input logic [DW-1:0] base);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, base + DW'(i), 1'b0, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_tick  = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
      ovf_clr  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid",    32'(rd_valid), 32'd0);
      check("rst_level",    32'(level),    32'd0);
      check("rst_full",     32'(full),     32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte, one-cycle latency.
      cyc(1'b1, 8'h35, 1'b0, 1'b0);
      check("t1_valid", 32'(rd_valid), 32'd1);
      check("t1_data",  32'(rd_data),  32'h35);
      check("t1_level", 32'(level),    32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("t1_empty_valid", 32'(rd_valid), 32'd0);
      check("t1_empty_level", 32'(level),    32'd0);

      // Fill then drain in order.
      fill(8'h30);
      check("t2_full",  32'(full),  32'd1);
      check("t2_level", 32'(level), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         check("t2_drain_data", 32'(rd_data), 32'h30 + 32'(i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         if (i == 0) check("t2_full_drop", 32'(full), 32'd0);
      end
      check("t2_end_valid", 32'(rd_valid), 32'd0);

      // Write accepted while full because a read happens in the same cycle.
      fill(8'h40);
      cyc(1'b1, 8'h0D, 1'b1, 1'b0);
      check("t3_level",    32'(level),    32'd16);
      check("t3_overflow", 32'(overflow), 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         check("t3_drain_data", 32'(rd_data), (i == DEPTH) ? 32'h0D : 32'h40 + 32'(i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Drops while full, clear, and clear colliding with a drop.
      fill(8'h50);
      repeat (3) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_level",    32'(level),    32'd16);
`ifdef RXFIFO_OVF_COUNT_EN
      check("t4_count3", 32'(ovf_count), 32'd3);
`endif
      cyc(1'b1, 8'hBB, 1'b0, 1'b1);
      check("t4_clr_drop_ovf", 32'(overflow), 32'd1);
`ifdef RXFIFO_OVF_COUNT_EN
      check("t4_clr_drop_count", 32'(ovf_count), 32'd1);
`endif
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("t4_clr_ovf", 32'(overflow), 32'd0);
`ifdef RXFIFO_OVF_COUNT_EN
      check("t4_clr_count", 32'(ovf_count), 32'd0);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         check("t4_drain_data", 32'(rd_data), 32'h50 + 32'(i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Streaming 40 bytes through, wrapping pointers more than twice.
      cyc(1'b1, 8'h60, 1'b0, 1'b0);
      for (int i = 1; i < 40; i++) begin
         check("t5_stream_data",  32'(rd_data), 32'h60 + 32'(i - 1));
         check("t5_stream_level", 32'(level),   32'd1);
         cyc(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
      end
      check("t5_last_data", 32'(rd_data), 32'h87);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("t5_end_level", 32'(level), 32'd0);

      // Asynchronous reset with data and overflow pending.
      fill(8'h70);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      repeat (9) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6_pre_level",    32'(level),    32'd7);
      check("t6_pre_overflow", 32'(overflow), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid",    32'(rd_valid), 32'd0);
      check("t6_async_level",    32'(level),    32'd0);
      check("t6_async_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      check("t6_post_data",  32'(rd_data), 32'h5A);
      check("t6_post_level", 32'(level),   32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("t6_post_empty", 32'(rd_valid), 32'd0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
